// File: rtl/custom_write_pkg.sv
// custom_write_pkg: encodings and default constants shared by the
// arbiter-side custom writer blocks.
//   state_t       - 2-bit FSM encoding (IDLE=0, REQ=1, WRITE=2, DONE=3)
//   DEF_*         - default parameter values for custom_write_burst
//   state_is_busy - helper: any state other than IDLE counts as busy
package custom_write_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_W_ADDR    = 12;
  localparam int unsigned DEF_W_DATA    = 128;
  localparam int unsigned DEF_N_WORDS   = 4;
  localparam int unsigned DEF_BASE_ADDR = 5;
  localparam logic [39:0] DEF_SEED      = 40'hff_ffff_ff50;

  function automatic logic state_is_busy(input state_t st);
    return (st != IDLE);
  endfunction

endpackage

// File: rtl/custom_write_burst_if.sv
// custom_write_burst_if: trigger, arbiter handshake and RAM port-A write
// bus of the burst writer.
//   master modport - the writer (drives req/wren/addr/data/busy/done)
//   slave modport  - the environment (drives data_rdy and the grant)
interface custom_write_burst_if
  import custom_write_pkg::*;
#(
  parameter int unsigned W_ADDR = DEF_W_ADDR,
  parameter int unsigned W_DATA = DEF_W_DATA
) ();

  logic              data_rdy;
  logic              custom_gnt;
  logic              custom_req;
  logic              custom_wren_a;
  logic [W_ADDR-1:0] custom_wr_addr;
  logic [W_DATA-1:0] custom_wr_data;
  logic              custom_busy;
  logic              custom_done;

  modport master (
    input  data_rdy, custom_gnt,
    output custom_req, custom_wren_a, custom_wr_addr, custom_wr_data,
           custom_busy, custom_done
  );

  modport slave (
    output data_rdy, custom_gnt,
    input  custom_req, custom_wren_a, custom_wr_addr, custom_wr_data,
           custom_busy, custom_done
  );

endinterface

// File: rtl/custom_write_burst_rise_detect.sv
// rise_detect: 1-bit registered rising-edge detector with synchronous reset.
//   clk  - clock
//   rst  - synchronous active-high reset
//   d    - level input
//   rise - high for the cycle in which d is 1 and was 0 on the previous edge
// The first cycle after reset is masked: the previous level is unknown
// there, so a level already high across reset release must not count.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q_r;
  logic armed_r;

  // Previous-level register plus the post-reset arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      q_r     <= d;
      armed_r <= 1'b1;
    end
  end

  assign rise = d & ~q_r & armed_r;

endmodule

// File: rtl/custom_write_burst.sv
// custom_write_burst: on each rising edge of data_rdy, requests RAM port A
// and writes N_WORDS consecutive words (addr BASE_ADDR+i, data SEED+i),
// writing only on granted cycles, then pulses done for one cycle.
//   clk        - clock, rising edge
//   custom_rst - synchronous active-high reset
//   bus        - custom_write_burst_if master: data_rdy/custom_gnt in;
//                req, wren_a, wr_addr, wr_data, busy, done out
// A trigger arriving while busy is remembered in a one-deep pending flag.
module custom_write_burst
  import custom_write_pkg::*;
#(
  parameter int unsigned       W_ADDR    = DEF_W_ADDR,
  parameter int unsigned       W_DATA    = DEF_W_DATA,
  parameter int unsigned       N_WORDS   = DEF_N_WORDS,
  parameter int unsigned       BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [W_DATA-1:0] SEED      = W_DATA'(DEF_SEED)
) (
  input  logic                  clk,
  input  logic                  custom_rst,
  custom_write_burst_if.master  bus
);

  // One extra bit so idx can step past the last word without overflow.
  localparam int unsigned IW = $clog2(N_WORDS + 1);

  state_t         state_r;
  state_t         state_nxt_s;
  logic [IW-1:0]  idx_r;
  logic [IW-1:0]  idx_nxt_s;
  logic           pending_r;
  logic           pending_nxt_s;
  logic           trig_s;
  logic           req_s;
  logic           wren_s;
  logic           done_s;
  logic           last_s;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (custom_rst),
    .d    (bus.data_rdy),
    .rise (trig_s)
  );

  assign last_s = (idx_r == IW'(N_WORDS - 1));

  // State, word index and pending-trigger registers.
  always_ff @(posedge clk) begin
    if (custom_rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Next-state, index/pending update and handshake outputs.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    pending_nxt_s = pending_r;
    req_s         = 1'b0;
    wren_s        = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_s || pending_r) begin
          state_nxt_s   = REQ;
          idx_nxt_s     = '0;
          pending_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      REQ: begin
        req_s = 1'b1;
        if (trig_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
        if (bus.custom_gnt) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WRITE: begin
        req_s  = 1'b1;
        wren_s = bus.custom_gnt;
        if (trig_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
        // A dropped grant is a stall: nothing written, idx holds.
        if (bus.custom_gnt) begin
          idx_nxt_s = idx_r + IW'(1);
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = WRITE;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      DONE: begin
        done_s = 1'b1;
        // A trigger seen in this very cycle goes straight to REQ as well,
        // so it cannot fall between DONE and IDLE.
        if (pending_r || trig_s) begin
          state_nxt_s   = REQ;
          idx_nxt_s     = '0;
          pending_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        idx_nxt_s     = '0;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.custom_req     = req_s;
  assign bus.custom_wren_a  = wren_s;
  assign bus.custom_done    = done_s;
  assign bus.custom_busy    = state_is_busy(state_r);
  // Both wrap naturally at their widths.
  assign bus.custom_wr_addr = W_ADDR'(BASE_ADDR) + W_ADDR'(idx_r);
  assign bus.custom_wr_data = SEED + W_DATA'(idx_r);

endmodule
